// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - decode-stage hazard scheduler for the 5-stage MIPS pipeline
//
// Purpose: decodes the decode-stage instruction, tracks shadow records of the
// execute and memory stages, and produces stall, flush and branch-operand
// forwarding controls plus a saturating stall-cycle counter.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   InstructionD  instruction held in the decode register
//   ValidD        InstructionD is real (0 = bubble)
//   BranchTakenD  beq in decode resolved taken
//   ClearCount    synchronous clear of StallCount
//   StallF/StallD hold fetch / decode registers
//   FlushE        insert bubble into execute
//   FlushD        kill wrong-path instruction in decode
//   ForwardAD/BD  branch operand rs/rt from memory-stage ALU result
//   StallCount    saturating stall-cycle count
module hazard_stall_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstructionD,
  input  logic        ValidD,
  input  logic        BranchTakenD,
  input  logic        ClearCount,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FlushD,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [15:0] StallCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       writes;
    logic       is_load;
  } rec_t;

  rec_t e_rec;
  rec_t m_rec;
  rec_t d_rec;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       use_rs;
  logic       use_rt;
  logic       d_branch;
  logic [4:0] d_dest;
  logic       d_load;

  // shamt/funct do not influence hazards
  logic unused_low;
  assign unused_low = ^InstructionD[10:0];

  assign opcode = InstructionD[31:26];
  assign rs     = InstructionD[25:21];
  assign rt     = InstructionD[20:16];
  assign rd     = InstructionD[15:11];

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    d_dest   = 5'd0;
    d_load   = 1'b0;
    d_branch = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        d_dest = rd;
      end
      OP_LW: begin
        use_rs = 1'b1;
        d_dest = rt;
        d_load = 1'b1;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        d_branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    d_rec.valid   = 1'b1;
    d_rec.dest    = d_dest;
    d_rec.writes  = (d_dest != 5'd0);
    d_rec.is_load = d_load;
  end

  // Register 0 is hardwired, so a zero source can never depend on anything.
  logic rs_live;
  logic rt_live;
  assign rs_live = use_rs & (rs != 5'd0);
  assign rt_live = use_rt & (rt != 5'd0);

  logic e_src_hit;
  logic m_src_hit;
  assign e_src_hit = (rs_live & (rs == e_rec.dest)) | (rt_live & (rt == e_rec.dest));
  assign m_src_hit = (rs_live & (rs == m_rec.dest)) | (rt_live & (rt == m_rec.dest));

  logic load_use;
  logic branch_haz;
  logic stall;

  assign load_use   = ValidD & e_rec.valid & e_rec.is_load & e_rec.writes & e_src_hit;
  // beq compares in decode, so it must wait for any E producer and for a load
  // still in M (load data is only available after writeback).
  assign branch_haz = ValidD & d_branch &
                      ((e_rec.valid & e_rec.writes & e_src_hit) |
                       (m_rec.valid & m_rec.is_load & m_src_hit));
  assign stall      = load_use | branch_haz;

  logic m_alu_result;
  assign m_alu_result = ValidD & m_rec.valid & m_rec.writes & ~m_rec.is_load;

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign FlushD    = BranchTakenD & ~stall;
  assign ForwardAD = m_alu_result & (m_rec.dest == rs) & (rs != 5'd0);
  assign ForwardBD = m_alu_result & (m_rec.dest == rt) & (rt != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rec      <= '0;
      m_rec      <= '0;
      StallCount <= 16'h0000;
    end else begin
      m_rec <= e_rec;
      if (stall | ~ValidD | FlushD) begin
        e_rec <= '0;
      end else begin
        e_rec <= d_rec;
      end
      if (ClearCount) begin
        StallCount <= 16'h0000;
      end else if (stall && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        valid = 1'b0;
  logic        bt = 1'b0;
  logic        clr = 1'b0;
  logic        stall_f, stall_d, flush_e, flush_d, fwd_a, fwd_b;
  logic [15:0] stall_count;

  hazard_stall_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .InstructionD (instr),
    .ValidD       (valid),
    .BranchTakenD (bt),
    .ClearCount   (clr),
    .StallF       (stall_f),
    .StallD       (stall_d),
    .FlushE       (flush_e),
    .FlushD       (flush_d),
    .ForwardAD    (fwd_a),
    .ForwardBD    (fwd_b),
    .StallCount   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flushd;
    logic        fa;
    logic        fb;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  event probe_ev;

  // reference model: the two older in-flight instructions, kept as raw words
  bit          e_v = 0;
  bit          m_v = 0;
  logic [31:0] e_ins = 32'h0;
  logic [31:0] m_ins = 32'h0;
  int unsigned mcnt = 0;

  typedef struct {
    bit use_rs;
    bit use_rt;
    bit ld;
    bit br;
    int rs;
    int rt;
    int dst;
  } dec_t;

  function automatic dec_t dec(logic [31:0] i);
    dec_t d;
    d = '{default: 0};
    d.rs = int'(i[25:21]);
    d.rt = int'(i[20:16]);
    case (i[31:26])
      6'h00: begin d.use_rs = 1; d.use_rt = 1; d.dst = int'(i[15:11]); end
      6'h23: begin d.use_rs = 1; d.dst = int'(i[20:16]); d.ld = 1; end
      6'h2b: begin d.use_rs = 1; d.use_rt = 1; end
      6'h04: begin d.use_rs = 1; d.use_rt = 1; d.br = 1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic bit reads(dec_t d, int r);
    return (r != 0) && ((d.use_rs && d.rs == r) || (d.use_rt && d.rt == r));
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] enc_lw(logic [4:0] rt, logic [4:0] rs);
    return {6'h23, rs, rt, 16'h0004};
  endfunction
  function automatic logic [31:0] enc_sw(logic [4:0] rt, logic [4:0] rs);
    return {6'h2b, rs, rt, 16'h0008};
  endfunction
  function automatic logic [31:0] enc_beq(logic [4:0] rs, logic [4:0] rt);
    return {6'h04, rs, rt, 16'h0010};
  endfunction

  task automatic chk(string n, logic [15:0] act, logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, want);
    end
  endtask

  // one pipeline cycle: drive inputs, predict outputs, then advance the model
  task automatic step(logic [31:0] i, bit v, bit b, bit c, string tag);
    dec_t de, dm, dd;
    bit lu, bh, st, fd, fa, fb;
    @(posedge clk);
    #1;
    instr = i; valid = v; bt = b; clr = c;
    de = dec(e_ins);
    dm = dec(m_ins);
    dd = dec(i);
    lu = v && e_v && de.ld && reads(dd, de.dst);
    bh = v && dd.br && ((e_v && reads(dd, de.dst)) || (m_v && dm.ld && reads(dd, dm.dst)));
    st = lu || bh;
    fd = b && !st;
    fa = v && m_v && !dm.ld && dm.dst != 0 && dm.dst == dd.rs;
    fb = v && m_v && !dm.ld && dm.dst != 0 && dm.dst == dd.rt;
    sbq.push_back('{st, fd, fa, fb, mcnt[15:0], tag});
    if (c) mcnt = 0;
    else if (st && mcnt < 65535) mcnt = mcnt + 1;
    m_v = e_v; m_ins = e_ins;
    if (st || !v || fd) e_v = 0;
    else begin e_v = 1; e_ins = i; end
  endtask

  task automatic nop(string tag);
    step(32'h0, 0, 0, 0, tag);
  endtask

  // monitor: compares every DUT presentation against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".StallF"}, 16'(stall_f), 16'(e.stall));
        chk({e.tag, ".StallD"}, 16'(stall_d), 16'(e.stall));
        chk({e.tag, ".FlushE"}, 16'(flush_e), 16'(e.stall));
        chk({e.tag, ".FlushD"}, 16'(flush_d), 16'(e.flushd));
        chk({e.tag, ".ForwardAD"}, 16'(fwd_a), 16'(e.fa));
        chk({e.tag, ".ForwardBD"}, 16'(fwd_b), 16'(e.fb));
        chk({e.tag, ".StallCount"}, stall_count, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [5];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h08;

    // in reset with a live-looking instruction: everything must be zero
    instr = enc_lw(5'd2, 5'd1); valid = 1;
    #3;
    sbq.push_back('{0, 0, 0, 0, 16'h0, "in_reset"});
    -> probe_ev;
    #4;
    valid = 0;
    rst_n = 1;

    // load-use: one stall cycle
    step(enc_lw(5'd2, 5'd1), 1, 0, 0, "lu.lw");
    step(enc_r(5'd3, 5'd2, 5'd4), 1, 0, 0, "lu.add_stall");
    step(enc_r(5'd3, 5'd2, 5'd4), 1, 0, 0, "lu.add_go");
    nop("lu.nop");
    nop("lu.nop2");

    // ALU producer then beq: one stall, then forward A
    step(enc_r(5'd2, 5'd1, 5'd1), 1, 0, 0, "alu.add");
    step(enc_beq(5'd2, 5'd0), 1, 0, 0, "alu.beq_stall");
    step(enc_beq(5'd2, 5'd0), 1, 0, 0, "alu.beq_fwd");
    nop("alu.nop");
    nop("alu.nop2");

    // lw then beq: two stalls, then no forwarding
    step(enc_lw(5'd5, 5'd1), 1, 0, 0, "lwb.lw");
    step(enc_beq(5'd5, 5'd6), 1, 0, 0, "lwb.beq1");
    step(enc_beq(5'd5, 5'd6), 1, 0, 0, "lwb.beq2");
    step(enc_beq(5'd5, 5'd6), 1, 0, 0, "lwb.beq3");
    nop("lwb.nop");
    nop("lwb.nop2");

    // register 0 never hazards; sw has no destination
    step(enc_lw(5'd0, 5'd1), 1, 0, 0, "z.lw0");
    step(enc_r(5'd3, 5'd0, 5'd0), 1, 0, 0, "z.add0");
    step(enc_sw(5'd2, 5'd1), 1, 0, 0, "z.sw");
    step(enc_r(5'd4, 5'd2, 5'd2), 1, 0, 0, "z.add");
    nop("z.nop");
    nop("z.nop2");

    // taken branch: flush without hazard, suppressed during a stall
    step(enc_beq(5'd7, 5'd8), 1, 1, 0, "bt.free");
    nop("bt.nop");
    step(enc_lw(5'd7, 5'd1), 1, 0, 0, "bt.lw");
    step(enc_beq(5'd7, 5'd8), 1, 1, 0, "bt.stall1");
    step(enc_beq(5'd7, 5'd8), 1, 1, 0, "bt.stall2");
    step(enc_beq(5'd7, 5'd8), 1, 1, 0, "bt.go");
    nop("bt.nop2");

    // asynchronous reset in the middle of a load-use stall
    step(enc_lw(5'd2, 5'd1), 1, 0, 0, "rst.lw");
    step(enc_r(5'd3, 5'd2, 5'd4), 1, 0, 0, "rst.stall");
    @(negedge clk);
    #2;
    rst_n = 0;
    e_v = 0; m_v = 0; mcnt = 0;
    sbq.push_back('{0, 0, 0, 0, 16'h0, "rst.async"});
    #1;
    -> probe_ev;
    @(negedge clk);
    #2;
    rst_n = 1;

    // saturation: start just below the ceiling, then stall through it
    @(negedge clk);
    #2;
    force dut.StallCount = 16'hFFFC;
    #1;
    release dut.StallCount;
    mcnt = 16'hFFFC;
    for (int k = 0; k < 4; k++) begin
      step(enc_lw(5'd5, 5'd1), 1, 0, 0, "sat.lw");
      step(enc_beq(5'd5, 5'd6), 1, 0, 0, "sat.beq1");
      step(enc_beq(5'd5, 5'd6), 1, 0, 0, "sat.beq2");
    end
    step(enc_lw(5'd5, 5'd1), 1, 0, 0, "sat.lw_last");
    step(enc_beq(5'd5, 5'd6), 1, 0, 1, "sat.clear_during_stall");
    step(enc_beq(5'd5, 5'd6), 1, 0, 0, "sat.after_clear");
    nop("sat.nop");
    nop("sat.nop2");

    // randomized traffic over a tiny register file to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 4)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      step(w, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 49) == 0), "rnd");
    end
    nop("end");
    @(negedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline hazard scheduler for the 5-stage MIPS core. It decodes the decode-stage instruction into register sources and destination, and keeps its own shadow record of the instructions in the execute and memory stages. From these it produces fetch/decode stall, execute flush, decode flush and branch-operand forwarding controls. It sits beside the decode stage and drives the pipeline register enables and clears. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- InstructionD  in  32  instruction currently held in the decode pipeline register
- ValidD  in  1  InstructionD is a real instruction (0 = bubble)
- BranchTakenD  in  1  beq in decode resolved taken this cycle
- ClearCount  in  1  synchronous clear of StallCount
- StallF  out  1  hold PC / fetch register
- StallD  out  1  hold decode register
- FlushE  out  1  clear execute register (insert bubble)
- FlushD  out  1  clear decode register (kill wrong-path fetch)
- ForwardAD  out  1  branch operand A (rs) taken from memory-stage ALU result
- ForwardBD  out  1  branch operand B (rt) taken from memory-stage ALU result
- StallCount  out  16  number of stall cycles since reset/clear; saturates at 16'hFFFF

## Operation
- Decode of InstructionD[31:26]. Define rs = [25:21], rt = [20:16], rd = [15:11].
  - 000000 (R-type): sources rs and rt; destination rd.
  - 100011 (lw): source rs; destination rt; load flag set.
  - 101011 (sw): sources rs and rt; no destination.
  - 000100 (beq): sources rs and rt; no destination; branch flag set.
  - Any other opcode: no sources, no destination.
  - A destination of 0 counts as no write. A source of 0 never matches.
- Shadow records, one each for E and M: {valid, dest[4:0], writes, isLoad}.
- Hazard terms, each combinational and gated by ValidD:
  - loadUse: E.valid & E.isLoad & E.writes & E.dest equals a used source of D.
  - branchHaz: D is beq & ((E.valid & E.writes & E.dest matches rs or rt) | (M.valid & M.isLoad & M.dest matches rs or rt)).
  - stall = loadUse | branchHaz.
- Outputs:
  - StallF = StallD = FlushE = stall.
  - FlushD = BranchTakenD & ~stall.
  - ForwardAD = M.valid & M.writes & ~M.isLoad & (M.dest == rs) & (rs != 0). ForwardBD is the same with rt.
- Record update each edge:
  - M <= E.
  - E <= bubble if stall, ~ValidD, or FlushD. Otherwise E <= decoded D.
- StallCount update each edge:
  - ClearCount has priority and sets the count to 0.
  - Otherwise the count increments when stall = 1, holding at FFFF.

## Timing
- Reset (rst_n = 0, asynchronous) sets E and M invalid and StallCount to 0.
- While in reset and after it, with ValidD = 0, every output is 0.
- Outputs are combinational from InstructionD/ValidD and the registered records, giving zero-cycle latency in the same cycle.
- Load-use costs exactly 1 stall cycle. The bubble enters E, the load moves to M, and the hazard clears the next cycle.
- beq after an ALU producer costs 1 stall cycle, then resolves with ForwardAD/BD = 1.
- beq directly after a lw costs 2 stall cycles, then proceeds with no forwarding, since the load has written back.
- BranchTakenD together with stall gives FlushD = 0; the branch is re-evaluated next cycle.
- If rst_n is asserted mid-stall, all records are lost; the stall drops immediately and asynchronously.
- ClearCount and stall in the same cycle give a count of 0.

## Test plan
- lw $2,0($1) then add $3,$2,$4 → one cycle with StallF/StallD/FlushE = 1, then 0; StallCount = 1.
- add $2,$1,$1 then beq $2,$0 → 1 stall cycle; the next cycle has ForwardAD = 1 and stall = 0.
- lw $5 then beq $5,$6 → stall high for exactly 2 consecutive cycles, then ForwardBD = 0; StallCount = 2.
- lw $0,0($1) then add $3,$0,$0 → no stall; sw $2 then add using $2 → no stall.
- beq with BranchTakenD = 1 and no hazard → FlushD = 1 for that cycle. The same stimulus during a hazard stall → FlushD = 0.
- Reset asserted during a load-use stall → outputs drop to 0 asynchronously; StallCount = 0.
- StallCount preloaded near FFFF by repeated stalls → holds at FFFF. Then ClearCount → 0.
